nibble_tx: RTL
==============

NIBBLE_TX -- requirements
Module: nibble_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit period (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port En, input, 1, load request; qualifies D.
REQ-005 SHALL have port D, input, 4, nibble to transmit.
REQ-006 SHALL have port ready, output, 1, high when a load will be accepted.
REQ-007 SHALL have port tx, output, 1, serial line; idle level 1.
REQ-008 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse at frame end.

Function
REQ-010 SHALL use FSM states IDLE, START, DATA, STOP (plus PARITY when configured), one-hot or binary, registered.
REQ-011 SHALL accept a load on a rising clk edge where En=1 and ready=1, capturing D into an internal 4-bit shift register.
REQ-012 SHALL drive ready=1 only in IDLE; ready SHALL be combinationally derived from state only, never from En.
REQ-013 SHALL ignore En and D while busy=1; captured data SHALL be unaffected.
REQ-014 SHALL transition IDLE->START on accept; tx=0 from the cycle after accept (one-cycle latency).
REQ-015 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads on every state change.
REQ-016 SHALL send 4 data bits LSB first in DATA using a 2-bit bit index; DATA->next state when index wraps 3->0 at period end.
REQ-017 SHALL drive tx=1 in STOP for one bit period, then return to IDLE.
REQ-018 SHALL pulse done=1 for exactly the one cycle in which STOP ends; busy SHALL deassert on the same edge that ends STOP.
REQ-019 SHALL accept a new load on the first cycle back in IDLE, giving back-to-back frames with no idle gap beyond one clock.
REQ-020 SHALL register tx (glitch-free output).

Reset
REQ-021 SHALL, on reset=0, immediately and asynchronously force state=IDLE, tx=1, busy=0, done=0, counters=0, shift register=0; ready=1 follows.
REQ-022 SHALL abort any frame in progress on reset mid-frame; no done pulse is produced for the aborted frame.
REQ-023 SHALL begin normal operation on the first rising clk edge after reset returns to 1.

Configuration
REQ-024 SHALL, when macro NIBBLE_TX_PARITY_EN is defined, insert state PARITY between DATA and STOP transmitting even parity (XOR of the 4 data bits) for one bit period; frame = 7 bit periods.
REQ-025 SHALL, when NIBBLE_TX_PARITY_EN is undefined, omit PARITY entirely; frame = 6 bit periods.

Structure
REQ-026 SHALL place the state enumeration, DATA_BITS=4 constant and the parity helper function in shared package nibble_tx_pkg.
REQ-027 SHALL implement bit-period timing in sub-module nibble_tx_baud (counter with restart input, tick output when count reaches CLKS_PER_BIT-1).

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL cover: reset, En=1, D=4'b1010 -> tx per bit period 0,0,1,0,1,1 (4 cycles each); done pulse in cycle 24 after accept; busy high cycles 1..24.
REQ-029 SHALL cover: with NIBBLE_TX_PARITY_EN, D=4'b0111 -> tx 0,1,1,1,0,1,1; frame 28 cycles.
REQ-030 SHALL cover: En=1, D=4'b0001 during busy (mid-DATA) -> frame unchanged, second nibble never sent.
REQ-031 SHALL cover: En held 1 with D=4'b1111 then 4'b0010 -> two back-to-back frames, second start bit one cycle after first done.
REQ-032 SHALL cover: reset=0 asserted mid-DATA -> tx=1, busy=0, ready=1 before next clk edge; no done pulse.
REQ-033 SHALL cover: En=0 for 20 cycles after reset -> tx stays 1, ready stays 1, done never pulses.

Source files
------------

// File: rtl/nibble_tx_pkg.sv
// Shared definitions for the nibble serial transmitter: FSM state encoding,
// payload width and the parity helper.
// Optional feature macro: NIBBLE_TX_PARITY_EN adds an even-parity bit
// between the last data bit and the stop bit.
package nibble_tx_pkg;

  localparam int DATA_BITS = 4;

  // Frame phases, in transmission order.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef NIBBLE_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nibble_tx_baud.sv
// Bit-period timer for nibble_tx. The counter runs 0..CLKS_PER_BIT-1 and
// wraps by itself. tick marks the last cycle of a bit period. pre_tick
// marks the cycle before it, so the FSM can register an end-of-period
// pulse. restart holds the count at zero.
module nibble_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] PRE  = 8'(CLKS_PER_BIT - 2);

  logic [7:0] count;

  // Count the cycles of the current bit period; wrap at the period end.
  // NOTE: sequential state is written with <= only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign tick     = (count == LAST);
  assign pre_tick = (count == PRE);

endmodule

// File: rtl/nibble_tx.sv
// Nibble serial transmitter. Each frame is a start bit (0), four data bits
// sent LSB first, an optional even-parity bit, and a stop bit (1). Every
// bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: NIBBLE_TX_PARITY_EN (7-bit-period frame when
// defined, 6 when undefined).
module nibble_tx
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 En,
  input  logic [DATA_BITS-1:0] D,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           bit_idx;
  logic                 tick;
  logic                 pre_tick;
`ifdef NIBBLE_TX_PARITY_EN
  logic                 parity;
`endif

  // A load is only possible in IDLE. En is not part of this term, so a
  // load request can never feed back into its own acceptance.
  assign ready = (state == S_IDLE);

  // Held at zero while idle, so the start bit gets a full period from the
  // accept edge. Every later state change falls on a tick, where the
  // counter wraps to zero by itself.
  nibble_tx_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (reset),
    .restart  (ready),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // Frame sequencer. tx, busy and done are registered here, so the outputs
  // change only on clock edges (or on reset).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef NIBBLE_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      // NOTE: done is a one-cycle strobe. It defaults low on every edge and
      // only the end-of-STOP branch raises it.
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (En) begin
            shreg  <= D;
`ifdef NIBBLE_TX_PARITY_EN
            parity <= even_parity(D);
`endif
            tx     <= 1'b0;
            busy   <= 1'b1;
            state  <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            bit_idx <= bit_idx + 2'd1;
            if (bit_idx == 2'(DATA_BITS - 1)) begin
`ifdef NIBBLE_TX_PARITY_EN
              tx    <= parity;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
`ifdef NIBBLE_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (pre_tick) begin
            // Raise done one edge early, so it is high during exactly the
            // last cycle of the stop bit.
            done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
